rotation_kick_resolver: RTL
===========================

Name: rotation_kick_resolver

Overview:
- Sits directly downstream of the rotation-candidate generator and upstream of game_control's piece commit.
- Takes the current piece and its rotated candidate, then tries SRS wall-kick offsets in order. Each shifted candidate goes to the board collision checker over a req/ack handshake.
- Returns the first non-colliding placement. If every offset collides, returns the unchanged current piece with success=0.

Parameters:
- MAX_KICKS, 5, number of kick tests per rotation (test 0 = no offset); legal range 1..5.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; ignored unless the block is idle
- abort  input  1  synchronous cancel; return to IDLE with no done pulse
- t_cur  input  tetromino_ctrl  piece before rotation; sampled on start
- t_cand  input  tetromino_ctrl  rotated candidate; sampled on start
- chk_req  output  1  collision-check request
- chk_piece  output  tetromino_ctrl  piece under test; stable while chk_req=1
- chk_ack  input  1  one-cycle pulse; chk_collide valid in the same cycle
- chk_collide  input  1  1 = the piece under test overlaps a wall, the floor or a locked cell
- t_out  output  tetromino_ctrl  resolved piece; valid while done=1
- success  output  1  1 = rotation accepted
- done  output  1  one-cycle completion pulse
- busy  output  1  high in every state except IDLE
- kick_idx  output  3  index of the accepted test; equals MAX_KICKS on failure

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - chk_req, done, success and busy are 0.
  - kick_idx is 0; t_out and chk_piece are all-zero.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On start=1, latch t_cur and t_cand and set test counter k=0.
  - Derive the transition from cur.rotation to cand.rotation:
    - to=from+1 is CW.
    - to=from-1 (mod 4) is CCW.
    - Any other value is NONE: only test 0 runs.
  - Move to REQ.
- REQ (1 cycle):
  - Drive chk_piece = cand, with x += dx[k] and y += dy[k].
  - Assert chk_req. Move to WAIT.
- WAIT:
  - Hold chk_req=1 and keep chk_piece stable until chk_ack=1.
  - On ack with chk_collide=0: set t_out=chk_piece, success=1, kick_idx=k. Go to DONE.
  - On ack with chk_collide=1 and k+1<limit: increment k and go to REQ. chk_req drops for exactly one cycle between tests.
  - On ack with chk_collide=1 and k+1=limit: set t_out=latched t_cur, success=0, kick_idx=MAX_KICKS. Go to DONE.
- Test limit:
  - 1 for the O piece and for a NONE transition.
  - MAX_KICKS otherwise.
- DONE:
  - done=1 for one cycle; success and t_out are held valid alongside it.
  - Next state is IDLE. success is cleared on the following cycle.
- Latency:
  - Minimum is start, REQ, WAIT with ack, DONE: done asserts 3 cycles after start.
  - Each extra test adds at least 2 cycles.
- Edge cases:
  - abort=1 in any state forces IDLE next cycle with chk_req=0 and no done pulse. An ack arriving in that cycle is discarded.
  - start while busy=1 is ignored. start and abort together in IDLE: abort wins.
  - Coordinate arithmetic is signed, width COORD_W, with no saturation. Out-of-range results go to the checker, which reports them as colliding.
  - Axes: x grows right, y grows down. SRS table entries are stored already y-negated.
- Kick tables:
  - JLSTZ, 0->1 (CW), in order: (0,0), (-1,0), (-1,-1), (0,+2), (-1,+2).
  - I, 0->1: (0,0), (-2,0), (+1,0), (-2,+1), (+1,-2).
  - The remaining 7 transitions per table follow standard SRS, y-negated.

Decomposition:
- GLOBAL.sv package:
  - tetromino_ctrl, with fields idx, rotation[1:0], coordinate.x, coordinate.y.
  - Shape enum and COORD_W.
  - kick_offset_t struct: signed dx, dy of 3 bits each.
  - rot_dir_t enum: CW, CCW, NONE.
- Sub-module srs_kick_table: purely combinational.
  - Inputs: shape, from_rot, dir, k.
  - Outputs: kick_offset_t and num_tests.
- FSM, latching and the handshake stay in rotation_kick_resolver.

Test Plan:
- T piece rot0->1 at (4,10), checker answers no collision at once:
  - chk_piece = (4,10,r1).
  - done 3 cycles after start, success=1, kick_idx=0, t_out=(4,10,r1).
- T piece rot0->1 at (4,10), collide on tests 0 and 1, clear on test 2:
  - chk_piece sequence (4,10), (3,10), (3,9).
  - t_out=(3,9,r1), kick_idx=2, success=1.
- I piece rot0->1 at (0,5), all 5 tests collide:
  - Exactly 5 requests, the second at x=-2.
  - success=0, t_out equals t_cur (rot0, (0,5)), kick_idx=5.
- O piece rot0->1, test 0 collides:
  - Exactly 1 request, then done with success=0.
- Multi-cycle ack and busy behaviour:
  - Ack delayed 4 cycles: chk_req and chk_piece stay stable for the full wait.
  - start pulsed while busy: no effect.
- abort asserted during WAIT: chk_req=0 next cycle, no done pulse, busy=0, and a new start is accepted normally. rst_n pulsed low mid-test: all outputs are at reset values immediately (asynchronously).

Source files
------------

// File: rtl/rotation_kick_resolver_pkg.sv
// Shared types for the rotation kick resolver: piece descriptor, kick offsets,
// rotation direction and FSM states.
package rotation_kick_resolver_pkg;

    localparam int unsigned COORD_W = 6;
    localparam int unsigned KIDX_W  = 3;

    typedef enum logic [2:0] {
        SHAPE_I, SHAPE_O, SHAPE_T, SHAPE_S, SHAPE_Z, SHAPE_J, SHAPE_L
    } shape_t;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } coordinate_t;

    typedef struct packed {
        shape_t      idx;
        logic [1:0]  rotation;
        coordinate_t coordinate;
    } tetromino_ctrl;

    typedef struct packed {
        logic signed [2:0] dx;
        logic signed [2:0] dy;
    } kick_offset_t;

    typedef enum logic [1:0] {ROT_CW, ROT_CCW, ROT_NONE} rot_dir_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} rkr_state_t;

    function automatic kick_offset_t kick(input int dx, input int dy);
        kick_offset_t o;
        o.dx = 3'(dx);
        o.dy = 3'(dy);
        return o;
    endfunction

    // Quarter-turn direction between two rotation states; anything else is NONE.
    function automatic rot_dir_t rot_dir(input logic [1:0] from_rot, input logic [1:0] to_rot);
        rot_dir_t d;
        d = ROT_NONE;
        if (to_rot == 2'(from_rot + 2'd1))
            d = ROT_CW;
        else if (to_rot == 2'(from_rot - 2'd1))
            d = ROT_CCW;
        return d;
    endfunction

endpackage

// File: rtl/rotation_kick_resolver_if.sv
// Request/result and collision-checker handshake bundle of the kick resolver.
interface rotation_kick_resolver_if;
    import rotation_kick_resolver_pkg::*;

    logic          start;
    logic          abort;
    tetromino_ctrl t_cur;
    tetromino_ctrl t_cand;
    logic          chk_req;
    tetromino_ctrl chk_piece;
    logic          chk_ack;
    logic          chk_collide;
    tetromino_ctrl t_out;
    logic          success;
    logic          done;
    logic          busy;
    logic [KIDX_W-1:0] kick_idx;

    modport slave (
        input  start, abort, t_cur, t_cand, chk_ack, chk_collide,
        output chk_req, chk_piece, t_out, success, done, busy, kick_idx
    );

    modport master (
        output start, abort, t_cur, t_cand, chk_ack, chk_collide,
        input  chk_req, chk_piece, t_out, success, done, busy, kick_idx
    );

endinterface

// File: rtl/rotation_kick_resolver_srs_kick_table.sv
// Combinational SRS wall-kick lookup (screen axes, y grows down).
module rotation_kick_resolver_srs_kick_table
    import rotation_kick_resolver_pkg::*;
#(
    parameter int unsigned MAX_KICKS = 5
) (
    input  shape_t            shape,
    input  logic [1:0]        from_rot,
    input  rot_dir_t          dir,
    input  logic [KIDX_W-1:0] k,
    output kick_offset_t      offset,
    output logic [KIDX_W-1:0] num_tests
);

    logic         is_i;
    logic         single;
    logic [1:0]   cw_from;
    kick_offset_t cw_off;

    // A CCW turn from r is the CW turn from r-1 played backwards: same row, negated.
    always_comb begin
        is_i    = (shape == SHAPE_I);
        single  = (shape == SHAPE_O) || (dir == ROT_NONE);
        cw_from = (dir == ROT_CCW) ? 2'(from_rot - 2'd1) : from_rot;
        cw_off  = kick(0, 0);
        case ({is_i, cw_from, k})
            {1'b0, 2'd0, 3'd1}: cw_off = kick(-1,  0);
            {1'b0, 2'd0, 3'd2}: cw_off = kick(-1, -1);
            {1'b0, 2'd0, 3'd3}: cw_off = kick( 0,  2);
            {1'b0, 2'd0, 3'd4}: cw_off = kick(-1,  2);
            {1'b0, 2'd1, 3'd1}: cw_off = kick( 1,  0);
            {1'b0, 2'd1, 3'd2}: cw_off = kick( 1,  1);
            {1'b0, 2'd1, 3'd3}: cw_off = kick( 0, -2);
            {1'b0, 2'd1, 3'd4}: cw_off = kick( 1, -2);
            {1'b0, 2'd2, 3'd1}: cw_off = kick( 1,  0);
            {1'b0, 2'd2, 3'd2}: cw_off = kick( 1, -1);
            {1'b0, 2'd2, 3'd3}: cw_off = kick( 0,  2);
            {1'b0, 2'd2, 3'd4}: cw_off = kick( 1,  2);
            {1'b0, 2'd3, 3'd1}: cw_off = kick(-1,  0);
            {1'b0, 2'd3, 3'd2}: cw_off = kick(-1,  1);
            {1'b0, 2'd3, 3'd3}: cw_off = kick( 0, -2);
            {1'b0, 2'd3, 3'd4}: cw_off = kick(-1, -2);
            {1'b1, 2'd0, 3'd1}: cw_off = kick(-2,  0);
            {1'b1, 2'd0, 3'd2}: cw_off = kick( 1,  0);
            {1'b1, 2'd0, 3'd3}: cw_off = kick(-2,  1);
            {1'b1, 2'd0, 3'd4}: cw_off = kick( 1, -2);
            {1'b1, 2'd1, 3'd1}: cw_off = kick(-1,  0);
            {1'b1, 2'd1, 3'd2}: cw_off = kick( 2,  0);
            {1'b1, 2'd1, 3'd3}: cw_off = kick(-1, -2);
            {1'b1, 2'd1, 3'd4}: cw_off = kick( 2,  1);
            {1'b1, 2'd2, 3'd1}: cw_off = kick( 2,  0);
            {1'b1, 2'd2, 3'd2}: cw_off = kick(-1,  0);
            {1'b1, 2'd2, 3'd3}: cw_off = kick( 2, -1);
            {1'b1, 2'd2, 3'd4}: cw_off = kick(-1,  2);
            {1'b1, 2'd3, 3'd1}: cw_off = kick( 1,  0);
            {1'b1, 2'd3, 3'd2}: cw_off = kick(-2,  0);
            {1'b1, 2'd3, 3'd3}: cw_off = kick( 1,  2);
            {1'b1, 2'd3, 3'd4}: cw_off = kick(-2, -1);
            default:            cw_off = kick(0, 0);
        endcase

        offset = kick(0, 0);
        if (!single) begin
            if (dir == ROT_CCW) begin
                offset.dx = 3'(-cw_off.dx);
                offset.dy = 3'(-cw_off.dy);
            end else begin
                offset = cw_off;
            end
        end
        num_tests = single ? KIDX_W'(1) : KIDX_W'(MAX_KICKS);
    end

endmodule

// File: rtl/rotation_kick_resolver.sv
// Tries SRS kick offsets on a rotated candidate through the collision checker
// and returns the first clear placement, or the unrotated piece on failure.
module rotation_kick_resolver
    import rotation_kick_resolver_pkg::*;
#(
    parameter int unsigned MAX_KICKS = 5
) (
    input logic                     clk,
    input logic                     rst_n,
    rotation_kick_resolver_if.slave bus
);

    rkr_state_t        state_q, state_d;
    tetromino_ctrl     cur_q, cur_d;
    tetromino_ctrl     cand_q, cand_d;
    rot_dir_t          dir_q, dir_d;
    logic [KIDX_W-1:0] k_q, k_d;

    logic              chk_req_q, chk_req_d;
    tetromino_ctrl     chk_piece_q, chk_piece_d;
    tetromino_ctrl     t_out_q, t_out_d;
    logic              success_q, success_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [KIDX_W-1:0] kick_idx_q, kick_idx_d;

    kick_offset_t      offset;
    logic [KIDX_W-1:0] num_tests;
    tetromino_ctrl     probe;

    rotation_kick_resolver_srs_kick_table #(
        .MAX_KICKS (MAX_KICKS)
    ) u_srs_kick_table (
        .shape     (cand_q.idx),
        .from_rot  (cur_q.rotation),
        .dir       (dir_q),
        .k         (k_q),
        .offset    (offset),
        .num_tests (num_tests)
    );

    // Next state, latches and registered outputs; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cand_d      = cand_q;
        dir_d       = dir_q;
        k_d         = k_q;
        chk_piece_d = chk_piece_q;
        t_out_d     = t_out_q;
        success_d   = success_q;
        kick_idx_d  = kick_idx_q;

        probe              = cand_q;
        probe.coordinate.x = cand_q.coordinate.x + COORD_W'(offset.dx);
        probe.coordinate.y = cand_q.coordinate.y + COORD_W'(offset.dy);

        if (bus.abort) begin
            state_d   = IDLE;
            success_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cur_d   = bus.t_cur;
                        cand_d  = bus.t_cand;
                        dir_d   = rot_dir(bus.t_cur.rotation, bus.t_cand.rotation);
                        k_d     = '0;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    chk_piece_d = probe;
                    state_d     = WAIT;
                end
                WAIT: begin
                    if (bus.chk_ack) begin
                        if (!bus.chk_collide) begin
                            t_out_d    = chk_piece_q;
                            success_d  = 1'b1;
                            kick_idx_d = k_q;
                            state_d    = DONE;
                        end else if ((k_q + KIDX_W'(1)) < num_tests) begin
                            k_d     = k_q + KIDX_W'(1);
                            state_d = REQ;
                        end else begin
                            t_out_d    = cur_q;
                            success_d  = 1'b0;
                            kick_idx_d = KIDX_W'(MAX_KICKS);
                            state_d    = DONE;
                        end
                    end
                end
                DONE: begin
                    success_d = 1'b0;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        chk_req_d = (state_d == WAIT);
        done_d    = (state_d == DONE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            cand_q      <= '0;
            dir_q       <= ROT_NONE;
            k_q         <= '0;
            chk_req_q   <= 1'b0;
            chk_piece_q <= '0;
            t_out_q     <= '0;
            success_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            kick_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cand_q      <= cand_d;
            dir_q       <= dir_d;
            k_q         <= k_d;
            chk_req_q   <= chk_req_d;
            chk_piece_q <= chk_piece_d;
            t_out_q     <= t_out_d;
            success_q   <= success_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            kick_idx_q  <= kick_idx_d;
        end
    end

    assign bus.chk_req   = chk_req_q;
    assign bus.chk_piece = chk_piece_q;
    assign bus.t_out     = t_out_q;
    assign bus.success   = success_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.kick_idx  = kick_idx_q;

endmodule
